compare_result_tracker: RTL and testbench
=========================================

COMPARE_RESULT_TRACKER -- requirements
Module: compare_result_tracker

Interface
REQ-001 SHALL provide parameter STABLE_CNT, default 4, legal range 1..15: consecutive identical valid samples required to commit a result.
REQ-002 SHALL provide clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL provide rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL provide sample_en, input, 1: flags sampled only on cycles where high.
REQ-005 SHALL provide less, equal, greater, input, 1 each: flags from the upstream 2-bit magnitude comparator.
REQ-006 SHALL provide clr_counts, input, 1: synchronous clear of counters and err.
REQ-007 SHALL provide result, output, 2: committed code; 00 none, 01 less, 10 equal, 11 greater.
REQ-008 SHALL provide result_valid, output, 1: high while a committed result is held.
REQ-009 SHALL provide changed, output, 1: one-cycle pulse on each commit.
REQ-010 SHALL provide cnt_less, cnt_equal, cnt_greater, output, 8 each: commit counts per result.
REQ-011 SHALL provide err, output, 1: sticky flag, set by a non-one-hot sample.

Function
REQ-012 All outputs SHALL be registered and update on the same edge that samples the qualifying input.
REQ-013 Sample is valid SHALL mean exactly one of less/equal/greater high while sample_en=1; candidate code = 01/10/11 respectively.
REQ-014 Run counter (4 bits): valid sample matching previous candidate -> run+1, saturating at STABLE_CNT; valid sample differing -> run=1 and candidate updated.
REQ-015 FSM states SHALL be IDLE (result_valid=0, result=00), LOCKED (result_valid=1), FAULT (result_valid=0, result=00).
REQ-016 IDLE->LOCKED and FAULT->LOCKED SHALL occur on the edge where run reaches STABLE_CNT; result<=candidate, changed=1, matching counter +1.
REQ-017 In LOCKED, run reaching STABLE_CNT with candidate != result SHALL commit the new code: changed=1, matching counter +1; run reaching STABLE_CNT with candidate == result SHALL produce no pulse and no count.
REQ-018 Any non-one-hot sample (zero flags or >1 flag) while sample_en=1 SHALL force FAULT from any state: err<=1, run<=0, candidate cleared, result<=00, result_valid<=0, no count.
REQ-019 With STABLE_CNT=1, every valid sample whose code differs from result SHALL commit on that edge.
REQ-020 sample_en=0 SHALL hold run, candidate, FSM state, result, counters; changed=0.
REQ-021 changed SHALL be high for exactly one cycle per commit, never two consecutive cycles without two consecutive commits.
REQ-022 Counters SHALL saturate at 255; no wrap to 0.
REQ-023 clr_counts=1 SHALL zero all three counters and err on that edge; it SHALL NOT alter FSM, run, result, result_valid.
REQ-024 clr_counts coincident with a commit: clear wins (counter reads 0), commit of result/changed still occurs.
REQ-025 clr_counts coincident with a non-one-hot sample: err reads 1 after the edge (fault wins over clear for err).

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, run=0, candidate=00, result=00, result_valid=0, changed=0, all counters=0, err=0, overriding all other inputs.
REQ-027 rst asserted mid-run (run between 1 and STABLE_CNT-1) SHALL discard the partial run; a fresh run of STABLE_CNT samples is needed after release.

Verification (STABLE_CNT=4)
REQ-028 After reset, 4 consecutive sample_en cycles with equal=1 -> result=10, result_valid=1, changed pulses once on 4th edge, cnt_equal=1; 3 samples only -> result_valid=0.
REQ-029 LOCKED on 10, then less=1 for 3 samples, greater=1 for 4 samples -> result=11 after 7th sample, cnt_less=0, cnt_greater=1, one changed pulse.
REQ-030 less=1 sampled twice, sample_en=0 five cycles, less=1 twice more -> commit on 4th sampled edge, result=01, cnt_less=1.
REQ-031 LOCKED on 01, sample with less=1 and greater=1 -> err=1, result=00, result_valid=0; then 4 samples greater=1 -> result=11, err still 1; clr_counts -> err=0, counters=0, result=11 retained.
REQ-032 Alternate 4x less / 4x greater for 600 commits -> cnt_less=cnt_greater=255, no wrap; rst on a cycle with 4th equal sample -> all outputs zero, no commit.

Source files
------------

// File: rtl/compare_result_tracker.sv
// Debounces one-hot comparator flags into a committed result code,
// with per-result commit counters and a sticky protocol-error flag.
module compare_result_tracker #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       less,
  input  logic       equal,
  input  logic       greater,
  input  logic       clr_counts,
  output logic [1:0] result,
  output logic       result_valid,
  output logic       changed,
  output logic [7:0] cnt_less,
  output logic [7:0] cnt_equal,
  output logic [7:0] cnt_greater,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  state_t     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [1:0] cand_q, cand_d;
  logic [1:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic       changed_q, changed_d;
  logic [7:0] cl_q, cl_d;
  logic [7:0] ce_q, ce_d;
  logic [7:0] cg_q, cg_d;
  logic       err_q, err_d;

  logic       onehot;
  logic       bad;
  logic       commit;
  logic [1:0] code;

  always_comb begin
    onehot = (less ^ equal ^ greater) & ~(less & equal & greater);
    bad    = sample_en & ~onehot;
    code   = less ? 2'b01 : (equal ? 2'b10 : 2'b11);

    state_d   = state_q;
    run_d     = run_q;
    cand_d    = cand_q;
    result_d  = result_q;
    changed_d = 1'b0;
    cl_d      = cl_q;
    ce_d      = ce_q;
    cg_d      = cg_q;
    err_d     = err_q;
    commit    = 1'b0;

    if (bad) begin
      state_d  = FAULT;
      run_d    = 4'd0;
      cand_d   = 2'b00;
      result_d = 2'b00;
      err_d    = 1'b1;
    end else if (sample_en) begin
      if (code == cand_q) begin
        run_d = (run_q >= STABLE) ? STABLE : run_q + 4'd1;
      end else begin
        run_d  = 4'd1;
        cand_d = code;
      end
      // A full run only commits when it carries news.
      commit = (run_d == STABLE) &&
               ((state_q != LOCKED) || (cand_d != result_q));
    end

    if (commit) begin
      state_d   = LOCKED;
      result_d  = cand_d;
      changed_d = 1'b1;
      unique case (cand_d)
        2'b01:   if (cl_q != 8'hff) cl_d = cl_q + 8'd1;
        2'b10:   if (ce_q != 8'hff) ce_d = ce_q + 8'd1;
        default: if (cg_q != 8'hff) cg_d = cg_q + 8'd1;
      endcase
    end

    if (clr_counts) begin
      cl_d  = 8'd0;
      ce_d  = 8'd0;
      cg_d  = 8'd0;
      err_d = bad;
    end

    valid_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      run_q     <= 4'd0;
      cand_q    <= 2'b00;
      result_q  <= 2'b00;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      cl_q      <= 8'd0;
      ce_q      <= 8'd0;
      cg_q      <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      cand_q    <= cand_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      cl_q      <= cl_d;
      ce_q      <= ce_d;
      cg_q      <= cg_d;
      err_q     <= err_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign changed      = changed_q;
  assign cnt_less     = cl_q;
  assign cnt_equal    = ce_q;
  assign cnt_greater  = cg_q;
  assign err          = err_q;

endmodule

// File: tb/tb_compare_result_tracker.sv
// Vector table plus scoreboard bench for compare_result_tracker,
// with a second STABLE_CNT=1 instance for the single-sample case.
module tb_compare_result_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sample_en, less, equal, greater, clr_counts;
  logic [1:0] result, result1;
  logic       result_valid, result_valid1;
  logic       changed, changed1;
  logic [7:0] cnt_less, cnt_equal, cnt_greater;
  logic [7:0] cnt_less1, cnt_equal1, cnt_greater1;
  logic       err, err1;

  compare_result_tracker #(.STABLE_CNT(4)) u_dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .less(less), .equal(equal), .greater(greater),
    .clr_counts(clr_counts), .result(result),
    .result_valid(result_valid), .changed(changed),
    .cnt_less(cnt_less), .cnt_equal(cnt_equal),
    .cnt_greater(cnt_greater), .err(err)
  );

  compare_result_tracker #(.STABLE_CNT(1)) u_dut1 (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .less(less), .equal(equal), .greater(greater),
    .clr_counts(clr_counts), .result(result1),
    .result_valid(result_valid1), .changed(changed1),
    .cnt_less(cnt_less1), .cnt_equal(cnt_equal1),
    .cnt_greater(cnt_greater1), .err(err1)
  );

  typedef struct {
    logic       rst, en, clr;
    logic [2:0] f;
    logic [1:0] res;
    logic       vld, chg, err;
    logic [7:0] cl, ce, cg;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int row = 0;

  localparam logic [2:0] L = 3'b100;
  localparam logic [2:0] E = 3'b010;
  localparam logic [2:0] G = 3'b001;

  function automatic vec_t mk(
    logic r, logic en, logic c, logic [2:0] f,
    logic [1:0] res, logic v, logic ch, logic e,
    logic [7:0] cl, logic [7:0] ce, logic [7:0] cg);
    vec_t t;
    t.rst = r; t.en = en; t.clr = c; t.f = f;
    t.res = res; t.vld = v; t.chg = ch; t.err = e;
    t.cl = cl; t.ce = ce; t.cg = cg;
    return t;
  endfunction

  task automatic step(input vec_t v);
    vec_t x;
    @(negedge clk);
    rst = v.rst; sample_en = v.en; clr_counts = v.clr;
    {less, equal, greater} = v.f;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    checks++;
    if (result !== x.res || result_valid !== x.vld ||
        changed !== x.chg || err !== x.err ||
        cnt_less !== x.cl || cnt_equal !== x.ce ||
        cnt_greater !== x.cg) begin
      errors++;
      $display("FAIL row%0d got res=%b vld=%b chg=%b err=%b cnt=%0d/%0d/%0d required res=%b vld=%b chg=%b err=%b cnt=%0d/%0d/%0d",
               row, result, result_valid, changed, err,
               cnt_less, cnt_equal, cnt_greater,
               x.res, x.vld, x.chg, x.err, x.cl, x.ce, x.cg);
    end
    row++;
  endtask

  task automatic chk1(input string nm, input logic [1:0] res,
                      input logic chg, input logic [7:0] cl,
                      input logic [7:0] cg);
    checks++;
    if (result1 !== res || changed1 !== chg ||
        cnt_less1 !== cl || cnt_greater1 !== cg) begin
      errors++;
      $display("FAIL %s got res=%b chg=%b cl=%0d cg=%0d required res=%b chg=%b cl=%0d cg=%0d",
               nm, result1, changed1, cnt_less1, cnt_greater1,
               res, chg, cl, cg);
    end
  endtask

  initial begin
    logic [1:0] eres;
    logic       evld;
    int nl, ng;

    rst = 1'b1; sample_en = 1'b0; clr_counts = 1'b0;
    less = 1'b0; equal = 1'b0; greater = 1'b0;

    // reset, then equal x4 commits
    tbl.push_back(mk(1,0,0,0, 2'b00,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,E, 2'b00,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,E, 2'b00,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,E, 2'b00,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,E, 2'b10,1,1,0, 0,1,0));
    tbl.push_back(mk(0,1,0,E, 2'b10,1,0,0, 0,1,0));
    // less x3 then greater x4
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0,L, 2'b10,1,0,0, 0,1,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0,G, 2'b10,1,0,0, 0,1,0));
    tbl.push_back(mk(0,1,0,G, 2'b11,1,1,0, 0,1,1));
    // less x2, idle x5 with junk flags, less x2
    tbl.push_back(mk(0,1,0,L, 2'b11,1,0,0, 0,1,1));
    tbl.push_back(mk(0,1,0,L, 2'b11,1,0,0, 0,1,1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,3'b111, 2'b11,1,0,0, 0,1,1));
    tbl.push_back(mk(0,1,0,L, 2'b11,1,0,0, 0,1,1));
    tbl.push_back(mk(0,1,0,L, 2'b01,1,1,0, 1,1,1));
    // two flags -> fault, recover on greater, then clear
    tbl.push_back(mk(0,1,0,3'b101, 2'b00,0,0,1, 1,1,1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0,G, 2'b00,0,0,1, 1,1,1));
    tbl.push_back(mk(0,1,0,G, 2'b11,1,1,1, 1,1,2));
    tbl.push_back(mk(0,0,1,0, 2'b11,1,0,0, 0,0,0));
    // clear coincident with commit: count stays 0
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0,E, 2'b11,1,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,E, 2'b10,1,1,0, 0,0,0));
    // clear coincident with zero-flag sample: err wins
    tbl.push_back(mk(0,1,1,3'b000, 2'b00,0,0,1, 0,0,0));
    // reset mid-run discards partial run
    tbl.push_back(mk(0,1,0,G, 2'b00,0,0,1, 0,0,0));
    tbl.push_back(mk(0,1,0,G, 2'b00,0,0,1, 0,0,0));
    tbl.push_back(mk(1,1,0,G, 2'b00,0,0,0, 0,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0,G, 2'b00,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,G, 2'b11,1,1,0, 0,0,1));
    // reset on the would-be committing edge
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,0,E, 2'b11,1,0,0, 0,0,1));
    tbl.push_back(mk(1,1,0,E, 2'b00,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0, 2'b00,0,0,0, 0,0,0));

    foreach (tbl[i]) step(tbl[i]);

    // 600 alternating commits, counters must saturate
    nl = 0; ng = 0; eres = 2'b00; evld = 1'b0;
    for (int g = 0; g < 600; g++) begin
      for (int j = 0; j < 4; j++) begin
        logic cm;
        cm = (j == 3);
        if (cm) begin
          evld = 1'b1;
          if (g % 2 == 0) begin
            eres = 2'b01; if (nl < 255) nl++;
          end else begin
            eres = 2'b11; if (ng < 255) ng++;
          end
        end
        step(mk(0,1,0, (g % 2 == 0) ? L : G, eres, evld, cm, 0,
                8'(nl), 0, 8'(ng)));
      end
    end
    checks++;
    if (cnt_less !== 8'd255 || cnt_greater !== 8'd255) begin
      errors++;
      $display("FAIL sat got cl=%0d cg=%0d required 255/255",
               cnt_less, cnt_greater);
    end

    // single-sample commit instance
    step(mk(1,0,0,0, 2'b00,0,0,0, 0,0,0));
    chk1("s1_rst", 2'b00, 0, 0, 0);
    step(mk(0,1,0,L, 2'b00,0,0,0, 0,0,0));
    chk1("s1_less", 2'b01, 1, 1, 0);
    step(mk(0,1,0,L, 2'b00,0,0,0, 0,0,0));
    chk1("s1_less_again", 2'b01, 0, 1, 0);
    step(mk(0,1,0,G, 2'b00,0,0,0, 0,0,0));
    chk1("s1_greater", 2'b11, 1, 1, 1);
    step(mk(0,0,0,L, 2'b00,0,0,0, 0,0,0));
    chk1("s1_hold", 2'b11, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
